mem_access_stage: RTL and testbench

MEM-stage access unit between the EX/MEM pipeline register and the MEM/WB register. It turns the EX/MEM memory controls (MemRead/MemWrite size codes, ALUResult address, RegData2 store data) into a req/ack data-memory bus transaction. While a transaction is outstanding it stalls the pipeline. It also aligns and extends load data, resolves the branch decision (PCSrc), and flags misaligned, illegal or timed-out accesses.

---
 rtl/mem_access_stage.sv | 172 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM-stage access unit: turns EX/MEM memory controls into a req/ack bus transaction,
// stalls the pipeline while it is outstanding, and aligns/extends the returned load data.
module mas_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] sz,
  input  logic       we,
  input  logic [1:0] sel,
  input  logic [7:0] b,
  input  logic [7:0] h,
  input  logic [7:0] w,
  output logic       be,
  output logic [7:0] wb
);
  always_comb begin
    be = 1'b1;
    wb = w;
    if (we) begin
      case (sz)
        2'b11: begin be = (sel == 2'(LANE));        wb = b; end
        2'b10: begin be = (sel[1] == 1'(LANE / 2)); wb = h; end
        default: ;
      endcase
    end
  end
endmodule

module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [1:0]  MemRead,
  input  logic [1:0]  MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] RegData2,
  input  logic [31:0] AdderResult,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  input  logic        MemToReg,
  input  logic        RegWrite,
  input  logic [4:0]  R_destination,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_RData,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  output logic [3:0]  Mem_BE,
  output logic        Stall,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUResult_out,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [4:0]  R_destination_out,
  output logic        PCSrc,
  output logic [31:0] BranchTarget,
  output logic        AccessErr
);
  localparam int NUM_LANES = 4;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} st_t;

  st_t                          st;
  logic [CW-1:0]                cnt;
  logic                         to_q;
  logic [1:0]                   sz_q, lane_q;
  logic [31:0]                  rd_q;
  logic [NUM_LANES-1:0]         be_n;
  logic [NUM_LANES-1:0][7:0]    wd_n;
  logic                         rd_any, wr_any, one, mis, acc_ok, acc_bad, err;
  logic [1:0]                   sz;
  logic [31:0]                  sh, ld;
  logic                         unused_jump;

  assign unused_jump = Jump;   // Jump is resolved upstream; it never gates PCSrc here

  assign rd_any  = |MemRead;
  assign wr_any  = |MemWrite;
  assign one     = rd_any ^ wr_any;
  assign sz      = rd_any ? MemRead : MemWrite;
  assign mis     = ((sz == 2'b01) && (ALUResult[1:0] != 2'b00)) || ((sz == 2'b10) && ALUResult[0]);
  assign acc_ok  = one & ~mis;
  assign acc_bad = (rd_any & wr_any) | (one & mis);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mas_lane #(.LANE(i)) u_lane (
      .sz  (sz),
      .we  (wr_any),
      .sel (ALUResult[1:0]),
      .b   (RegData2[7:0]),
      .h   (RegData2[8*(i%2) +: 8]),
      .w   (RegData2[8*i +: 8]),
      .be  (be_n[i]),
      .wb  (wd_n[i])
    );
  end

  // Load data is shifted down by the lane captured at request time, then extended.
  assign sh = Mem_RData >> {lane_q, 3'b000};
  always_comb begin
    case (sz_q)
      2'b11:   ld = {{24{sh[7]}}, sh[7:0]};
      2'b10:   ld = {{16{sh[15]}}, sh[15:0]};
      default: ld = sh;
    endcase
  end

  assign Stall             = ((st == IDLE) & acc_ok) | (st == BUSY);
  assign err               = ((st == IDLE) & acc_bad) | ((st == DONE) & to_q);
  assign AccessErr         = err;
  assign RegWrite_out      = RegWrite & ~err;
  assign MemToReg_out      = MemToReg;
  assign R_destination_out = R_destination;
  assign ALUResult_out     = ALUResult;
  assign PCSrc             = Branch & Zero & ~Stall;
  assign BranchTarget      = AdderResult;
  assign ReadData_out      = rd_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st        <= IDLE;
      Mem_Req   <= 1'b0;
      Mem_We    <= 1'b0;
      Mem_BE    <= '0;
      Mem_Addr  <= '0;
      Mem_WData <= '0;
      cnt       <= '0;
      to_q      <= 1'b0;
      sz_q      <= '0;
      lane_q    <= '0;
      rd_q      <= '0;
    end else begin
      case (st)
        IDLE: begin
          to_q <= 1'b0;
          if (acc_ok) begin
            st        <= BUSY;
            Mem_Req   <= 1'b1;
            Mem_We    <= wr_any;
            Mem_Addr  <= {ALUResult[31:2], 2'b00};
            Mem_BE    <= be_n;
            Mem_WData <= wd_n;
            cnt       <= '0;
            sz_q      <= sz;
            lane_q    <= ALUResult[1:0];
          end else if (acc_bad) begin
            rd_q <= '0;
          end
        end
        BUSY: begin
          if (Mem_Ack) begin
            Mem_Req <= 1'b0;
            if (!Mem_We) rd_q <= ld;
            st <= DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            Mem_Req <= 1'b0;
            rd_q    <= '0;
            to_q    <= 1'b1;
            st      <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: an instruction-level model predicts every output per cycle.
module tb_mem_access_stage;
  localparam int TIMEOUT = 16;

  logic        Clk = 1'b0, Reset_n = 1'b0;
  logic [1:0]  MemRead = '0, MemWrite = '0;
  logic [31:0] ALUResult = '0, RegData2 = '0, AdderResult = '0, Mem_RData = '0;
  logic        Branch = 0, Zero = 0, Jump = 0, MemToReg = 0, RegWrite = 0, Mem_Ack = 0;
  logic [4:0]  R_destination = '0;
  logic        Mem_Req, Mem_We, Stall, RegWrite_out, MemToReg_out, PCSrc, AccessErr;
  logic [31:0] Mem_Addr, Mem_WData, ReadData_out, ALUResult_out, BranchTarget;
  logic [3:0]  Mem_BE;
  logic [4:0]  R_destination_out;

  always #5 Clk = ~Clk;

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUResult(ALUResult), .RegData2(RegData2), .AdderResult(AdderResult),
    .Branch(Branch), .Zero(Zero), .Jump(Jump), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .R_destination(R_destination), .Mem_Ack(Mem_Ack), .Mem_RData(Mem_RData),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_BE(Mem_BE), .Stall(Stall), .ReadData_out(ReadData_out), .ALUResult_out(ALUResult_out),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out), .R_destination_out(R_destination_out),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget), .AccessErr(AccessErr)
  );

  typedef struct packed {
    logic [1:0]  mr, mw;
    logic [31:0] addr, wd, rdata, adder;
    logic [7:0]  ack_at;
    logic        br, zero, jump, m2r, rw, spur;
    logic [4:0]  rd;
    logic [2:0]  lit;
    logic [31:0] lv, la;
    logic [3:0]  lb;
  } instr_t;

  instr_t      prog[$];
  instr_t      cur;
  int          c = 0;
  int          checks = 0, errors = 0;
  int          req_cnt = 0;
  logic [31:0] exp_rd = '0;
  bit          chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- instruction-level model ----
  function automatic bit is_legal(input instr_t t);
    logic [1:0] s;
    if ((t.mr != 0) == (t.mw != 0)) return 0;
    s = (t.mr != 0) ? t.mr : t.mw;
    if (s == 2'd1) return (t.addr % 4) == 0;
    if (s == 2'd2) return (t.addr % 2) == 0;
    return 1;
  endfunction

  function automatic bit is_bad(input instr_t t);
    return ((t.mr != 0) || (t.mw != 0)) && !is_legal(t);
  endfunction

  // Stall cycles: the IDLE cycle plus every BUSY cycle (Ack cycle or timeout length).
  function automatic int stall_len(input instr_t t);
    if (!is_legal(t)) return 0;
    return ((t.ack_at != 0) ? int'(t.ack_at) : TIMEOUT) + 1;
  endfunction

  function automatic logic [3:0] exp_be(input instr_t t);
    int lane = int'(t.addr % 4);
    if (t.mw == 2'd3) return 4'(1 << lane);
    if (t.mw == 2'd2) return (lane >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wd(input instr_t t);
    if (t.mw == 2'd3) return (t.wd % 256) * 32'h01010101;
    if (t.mw == 2'd2) return (t.wd % 65536) * 32'h00010001;
    return t.wd;
  endfunction

  function automatic logic [31:0] exp_ld(input instr_t t);
    logic [31:0] sh, v;
    sh = t.rdata >> (8 * int'(t.addr % 4));
    if (t.mr == 2'd3) begin v = sh % 256;   if (v >= 128)   v = v - 256;   return v; end
    if (t.mr == 2'd2) begin v = sh % 65536; if (v >= 32768) v = v - 65536; return v; end
    return t.rdata;
  endfunction

  // ---- per-cycle compare ----
  always @(negedge Clk) begin : cmp
    int s;
    bit st, rq, tmo, bad, err;
    if (chk_en) begin
      s   = stall_len(cur);
      st  = c < s;
      rq  = (c >= 1) && (c < s);
      tmo = is_legal(cur) && (cur.ack_at == 0);
      bad = is_bad(cur);
      err = (bad && c == 0) || (tmo && c == s);
      if (c == 0) req_cnt = 0;
      if (Mem_Req === 1'b1) req_cnt++;
      chkb("stall", Stall, st);
      chkb("mem_req", Mem_Req, rq);
      if (rq) begin
        chkb("mem_we", Mem_We, cur.mw != 0);
        chk("mem_addr", Mem_Addr, cur.addr - (cur.addr % 4));
        chk("mem_be", 32'(Mem_BE), 32'(exp_be(cur)));
        if (cur.mw != 0) chk("mem_wdata", Mem_WData, exp_wd(cur));
      end
      chkb("access_err", AccessErr, err);
      chkb("regwrite_out", RegWrite_out, cur.rw & ~err);
      chkb("pcsrc", PCSrc, cur.br & cur.zero & ~st);
      chk("branch_target", BranchTarget, cur.adder);
      chk("aluresult_out", ALUResult_out, cur.addr);
      chkb("memtoreg_out", MemToReg_out, cur.m2r);
      chk("rdest_out", 32'(R_destination_out), 32'(cur.rd));
      if (is_legal(cur) && c == s) begin
        if (tmo) exp_rd = '0;
        else if (cur.mr != 0) exp_rd = exp_ld(cur);
      end
      chk("readdata_out", ReadData_out, exp_rd);
      case (cur.lit)
        3'd1: if (c == s) chk("lit_rdata", ReadData_out, cur.lv);
        3'd2: if (c == 1) begin
          chk("lit_addr", Mem_Addr, cur.la);
          chk("lit_be", 32'(Mem_BE), 32'(cur.lb));
          chk("lit_wdata", Mem_WData, cur.lv);
        end
        3'd3: if (c == 0) begin
          chkb("lit_err", AccessErr, 1'b1);
          chkb("lit_rw", RegWrite_out, 1'b0);
          chkb("lit_nostall", Stall, 1'b0);
        end
        3'd4: if (c == 0) begin
          chkb("lit_pcsrc", PCSrc, 1'b1);
          chk("lit_target", BranchTarget, cur.lv);
        end
        3'd5: if (c == s) begin
          chk("lit_req_cycles", req_cnt, 16);
          chkb("lit_timeout_err", AccessErr, 1'b1);
          chk("lit_timeout_rd", ReadData_out, 32'h0);
        end
        default: ;
      endcase
      if (bad && c == 0) exp_rd = '0;
    end
  end

  // ---- stimulus ----
  task automatic add(input logic [1:0] mr, input logic [1:0] mw, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] rdata, input int ack,
                     input logic br, input logic zero, input logic spur, input logic [2:0] lit,
                     input logic [31:0] lv, input logic [31:0] la, input logic [3:0] lb);
    instr_t t;
    t.mr = mr; t.mw = mw; t.addr = addr; t.wd = wd; t.rdata = rdata; t.ack_at = 8'(ack);
    t.br = br; t.zero = zero; t.spur = spur; t.lit = lit; t.lv = lv; t.la = la; t.lb = lb;
    t.adder = 32'h1000 + 32'(prog.size() * 4);
    t.rw    = 1'b1;
    t.m2r   = (mr != 0);
    t.rd    = 5'(prog.size() + 1);
    t.jump  = 1'(prog.size() % 2);
    prog.push_back(t);
  endtask

  task automatic apply(input instr_t t);
    MemRead = t.mr; MemWrite = t.mw; ALUResult = t.addr; RegData2 = t.wd;
    AdderResult = t.adder; Branch = t.br; Zero = t.zero; Jump = t.jump;
    MemToReg = t.m2r; RegWrite = t.rw; R_destination = t.rd; Mem_RData = t.rdata;
  endtask

  // The bench acts as the pipeline: an instruction stays in EX/MEM for its modelled duration.
  task automatic run(input instr_t t);
    int s, dur;
    s   = stall_len(t);
    dur = (s == 0) ? 1 : s + 1;
    cur = t;
    apply(t);
    for (int k = 0; k < dur; k++) begin
      c = k;
      Mem_Ack = ((t.ack_at != 0) && (k == int'(t.ack_at))) || (t.spur && (k == 0 || k == dur - 1));
      @(posedge Clk); #1;
    end
    Mem_Ack = 1'b0;
  endtask

  initial begin
    instr_t nop;
    nop = '0;
    add(2'd1, 2'd0, 32'h100, 32'h0,        32'hDEADBEEF, 2,  0, 0, 0, 3'd1, 32'hDEADBEEF, 32'h0,   4'h0);
    add(2'd3, 2'd0, 32'h103, 32'h0,        32'h80112233, 1,  0, 0, 0, 3'd1, 32'hFFFFFF80, 32'h0,   4'h0);
    add(2'd2, 2'd0, 32'h102, 32'h0,        32'h80112233, 1,  0, 0, 0, 3'd1, 32'hFFFF8011, 32'h0,   4'h0);
    add(2'd0, 2'd3, 32'h201, 32'h000000A5, 32'h0,        1,  0, 0, 0, 3'd2, 32'hA5A5A5A5, 32'h200, 4'h2);
    add(2'd1, 2'd0, 32'h102, 32'h0,        32'h0,        0,  0, 0, 0, 3'd3, 32'h0,        32'h0,   4'h0);
    add(2'd0, 2'd0, 32'h0,   32'h0,        32'h0,        0,  1, 1, 1, 3'd4, 32'h00001014, 32'h0,   4'h0);
    add(2'd1, 2'd0, 32'h10,  32'h0,        32'h12345678, 3,  1, 1, 1, 3'd0, 32'h0,        32'h0,   4'h0);
    add(2'd0, 2'd2, 32'h302, 32'h1234ABCD, 32'h0,        2,  0, 0, 0, 3'd2, 32'hABCDABCD, 32'h300, 4'hC);
    add(2'd0, 2'd1, 32'h40,  32'h11223344, 32'h0,        1,  0, 0, 0, 3'd0, 32'h0,        32'h0,   4'h0);
    add(2'd1, 2'd0, 32'h500, 32'h0,        32'hFFFFFFFF, 0,  0, 0, 0, 3'd5, 32'h0,        32'h0,   4'h0);
    add(2'd1, 2'd1, 32'h0,   32'h0,        32'h0,        0,  0, 0, 0, 3'd3, 32'h0,        32'h0,   4'h0);
    add(2'd2, 2'd0, 32'h101, 32'h0,        32'h0,        0,  0, 0, 0, 3'd3, 32'h0,        32'h0,   4'h0);
    add(2'd3, 2'd0, 32'h600, 32'h0,        32'h0000007F, 16, 0, 0, 0, 3'd1, 32'h0000007F, 32'h0,   4'h0);
    add(2'd2, 2'd0, 32'h600, 32'h0,        32'h00007FFF, 1,  0, 0, 0, 3'd0, 32'h0,        32'h0,   4'h0);
    add(2'd0, 2'd0, 32'h0,   32'h0,        32'h0,        0,  1, 0, 0, 3'd0, 32'h0,        32'h0,   4'h0);

    // Reset state
    apply(nop);
    #23;
    chkb("rst_mem_req", Mem_Req, 1'b0);
    chkb("rst_mem_we", Mem_We, 1'b0);
    chk("rst_mem_be", 32'(Mem_BE), 32'h0);
    chk("rst_readdata", ReadData_out, 32'h0);
    chkb("rst_access_err", AccessErr, 1'b0);
    chkb("rst_stall", Stall, 1'b0);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    chk_en = 1;
    foreach (prog[i]) run(prog[i]);

    // Reset in the middle of an outstanding load
    chk_en = 0;
    add(2'd1, 2'd0, 32'h700, 32'h0, 32'h0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 4'h0);
    apply(prog[$]);
    for (int k = 0; k < 4; k++) begin @(posedge Clk); #1; end
    chkb("midbusy_req", Mem_Req, 1'b1);
    #2;
    Reset_n = 1'b0;
    #1;
    chkb("rst_midbusy_req", Mem_Req, 1'b0);
    chk("rst_midbusy_be", 32'(Mem_BE), 32'h0);
    chk("rst_midbusy_rd", ReadData_out, 32'h0);
    apply(nop);
    #1;
    chkb("rst_midbusy_stall", Stall, 1'b0);
    #3;
    Reset_n = 1'b1;
    exp_rd = '0;
    @(posedge Clk); #1;
    chk_en = 1;
    add(2'd1, 2'd0, 32'h104, 32'h0, 32'hCAFEF00D, 1, 0, 0, 0, 3'd1, 32'hCAFEF00D, 32'h0, 4'h0);
    run(prog[$]);
    run(prog[14]);
    chk_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
